// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core: PC-redirect encoding used by
// the decoder and fetch unit, fetch FSM states, and the default reset vector.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JREG   = 2'd3
  } ctrl_pc_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/mips_cpu_fetch_if.sv
// Avalon-style instruction memory bus between the fetch unit (master) and the
// instruction memory (slave).
interface mips_cpu_fetch_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/mips_cpu_fetch_target.sv
// Combinational branch/jump target for the instruction currently held in fetch:
// PC-relative branch, J-type region jump, or register jump.
module mips_cpu_fetch_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  ctrl_pc_e    ctrl_pc,
  input  logic [31:0] reg_target,
  output logic [31:0] target
);

  logic        [31:0] seq_pc;
  logic signed [31:0] branch_offset;
  logic               unused_opcode;

  assign seq_pc        = pc + 32'd4;
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    target = seq_pc;
    unique case (ctrl_pc)
      PC_SEQ:    target = seq_pc;
      PC_BRANCH: target = seq_pc + $unsigned(branch_offset);
      PC_JUMP:   target = {seq_pc[31:28], instr[25:0], 2'b00};
      PC_JREG:   target = reg_target;
    endcase
  end

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch unit: PC owner, Avalon read master, one-slot branch delay and
// halt-on-jump-to-zero. Optional misaligned-target trap: MIPS_FETCH_ALIGN_CHECK_EN.
module mips_cpu_fetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
  input  logic               clk,
  input  logic               reset,
  mips_cpu_fetch_if.master   avm,
  output logic [31:0]        Instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  ctrl_pc_e           CtrlPC,
  input  logic [31:0]        reg_target,
  output logic [31:0]        pc_out,
  output logic               active,
  output logic               fetch_fault
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  instr_n;
  logic         pending, pending_n;
  logic [31:0]  target_q, target_n;
  logic [31:0]  branch_target;
  logic [31:0]  seq_pc;
  logic [31:0]  next_raw;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         retire;

  mips_cpu_fetch_target u_target (
    .pc         (pc),
    .instr      (Instr),
    .ctrl_pc    (CtrlPC),
    .reg_target (reg_target),
    .target     (branch_target)
  );

  assign seq_pc   = pc + 32'd4;
  // A redirect only takes effect after the delay slot has retired.
  assign next_raw = pending ? target_q : seq_pc;
  assign retire   = (state == ST_HOLD) && instr_ready;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  logic fault;

  assign misaligned  = |next_raw[1:0];
  assign next_pc     = next_raw;
  assign fetch_fault = fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault <= 1'b0;
    else if (retire && misaligned)
      fault <= 1'b1;
  end
`else
  logic unused_low_bits;

  assign misaligned      = 1'b0;
  assign next_pc         = {next_raw[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign unused_low_bits = ^next_raw[1:0];
`endif

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instr_n   = Instr;
    pending_n = pending;
    target_n  = target_q;
    unique case (state)
      ST_FETCH: begin
        if (!avm.avm_waitrequest) begin
          instr_n = avm.avm_readdata;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          // A redirect issued from the delay slot itself is dropped.
          if (pending) begin
            pending_n = 1'b0;
          end else if (CtrlPC != PC_SEQ) begin
            pending_n = 1'b1;
            target_n  = branch_target;
          end
          if (misaligned || (next_pc == 32'd0)) begin
            state_n = ST_HALT;
          end else begin
            pc_n    = next_pc;
            state_n = ST_FETCH;
          end
        end
      end
      default: state_n = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      pc       <= RESET_VECTOR;
      Instr    <= 32'd0;
      pending  <= 1'b0;
      target_q <= 32'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      Instr    <= instr_n;
      pending  <= pending_n;
      target_q <= target_n;
    end
  end

  assign avm.avm_read    = (state == ST_FETCH);
  assign avm.avm_address = pc;
  assign instr_valid     = (state == ST_HOLD);
  assign active          = (state != ST_HALT);
  assign pc_out          = pc;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Bench for mips_cpu_fetch: directed scenarios plus randomized program flow,
// checked against a retirement-level model of PC sequencing.
module tb_mips_cpu_fetch;
  import mips_cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        instr_ready;
  ctrl_pc_e    ctrl_pc;
  logic [31:0] reg_target;
  logic [31:0] pc_out;
  logic        active;
  logic        fetch_fault;

  mips_cpu_fetch_if bus ();

  mips_cpu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .avm         (bus),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .CtrlPC      (ctrl_pc),
    .reg_target  (reg_target),
    .pc_out      (pc_out),
    .active      (active),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: program counter, delayed redirect, halt/fault.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_target;
  logic        m_pending;
  logic        m_halted;
  logic        m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_pc      = 32'hBFC00000;
    m_instr   = 32'd0;
    m_target  = 32'd0;
    m_pending = 1'b0;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
  endfunction

  function automatic void model_retire(input logic [1:0] c, input logic [31:0] rt,
                                       input logic [31:0] ins);
    logic [31:0] seq;
    logic [31:0] nxt;
    seq = m_pc + 32'd4;
    if (m_pending) begin
      nxt       = m_target;
      m_pending = 1'b0;
    end else begin
      nxt = seq;
      if (c != 2'd0) begin
        m_pending = 1'b1;
        case (c)
          2'd1:    m_target = seq + 32'(4 * int'($signed(ins[15:0])));
          2'd2:    m_target = (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
          default: m_target = rt;
        endcase
      end
    end
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    if ((nxt % 32'd4) != 32'd0) begin
      m_fault  = 1'b1;
      m_halted = 1'b1;
      return;
    end
`else
    nxt = nxt - (nxt % 32'd4);
`endif
    if (nxt == 32'd0) m_halted = 1'b1;
    else              m_pc     = nxt;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_bit("rst_read",   bus.avm_read, 1'b1);
    check("rst_addr",       bus.avm_address, 32'hBFC00000);
    check_bit("rst_valid",  instr_valid, 1'b0);
    check("rst_instr",      Instr, 32'd0);
    check_bit("rst_active", active, 1'b1);
    check_bit("rst_fault",  fetch_fault, 1'b0);
    check("rst_pc",         pc_out, 32'hBFC00000);
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Serve one read with the given number of wait cycles, then check the hold.
  task automatic do_fetch(input int waits, input logic [31:0] word);
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata    = $urandom;
    for (int i = 0; i < waits; i++) begin
      check_bit("stall_read",  bus.avm_read, 1'b1);
      check("stall_addr",      bus.avm_address, m_pc);
      check_bit("stall_valid", instr_valid, 1'b0);
      tick();
    end
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = word;
    check_bit("fetch_read",  bus.avm_read, 1'b1);
    check("fetch_addr",      bus.avm_address, m_pc);
    check_bit("fetch_valid", instr_valid, 1'b0);
    tick();
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata    = $urandom;
    instr_ready         = 1'b0;
    m_instr             = word;
    check_bit("hold_valid", instr_valid, 1'b1);
    check_bit("hold_read",  bus.avm_read, 1'b0);
    check("hold_instr",     Instr, word);
    check("hold_pc",        pc_out, m_pc);
    check_bit("hold_active", active, 1'b1);
  endtask

  task automatic retire(input logic [1:0] c, input logic [31:0] rt);
    instr_ready = 1'b1;
    ctrl_pc     = ctrl_pc_e'(c);
    reg_target  = rt;
    tick();
    instr_ready = 1'b0;
    ctrl_pc     = ctrl_pc_e'(2'($urandom_range(0, 3)));
    reg_target  = $urandom;
    model_retire(c, rt, m_instr);
    if (m_halted) begin
      check_bit("halt_active", active, 1'b0);
      check_bit("halt_read",   bus.avm_read, 1'b0);
      check_bit("halt_valid",  instr_valid, 1'b0);
      check("halt_pc",         pc_out, m_pc);
      check_bit("halt_fault",  fetch_fault, m_fault);
    end else begin
      check_bit("next_read",  bus.avm_read, 1'b1);
      check_bit("next_valid", instr_valid, 1'b0);
      check("next_addr",      bus.avm_address, m_pc);
    end
  endtask

  task automatic idle_halted(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      instr_ready = 1'b1;
      ctrl_pc     = ctrl_pc_e'(2'($urandom_range(0, 3)));
      tick();
      check_bit("idle_active", active, 1'b0);
      check_bit("idle_read",   bus.avm_read, 1'b0);
      check_bit("idle_valid",  instr_valid, 1'b0);
      check("idle_pc",         pc_out, m_pc);
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  c;
    logic [31:0] rt;
    int          r;

    reset               = 1'b1;
    instr_ready         = 1'b0;
    ctrl_pc             = PC_SEQ;
    reg_target          = 32'd0;
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata    = 32'd0;
    model_reset();

    // Reset fetch with zero-wait memory, then sequential retire.
    apply_reset();
    do_fetch(0, 32'h24020005);
    check("first_instr", Instr, 32'h24020005);
    retire(2'd0, 32'd0);
    check("seq_addr", bus.avm_address, 32'hBFC00004);

    // Three wait states; retire requests during the stall must be ignored.
    instr_ready = 1'b1;
    do_fetch(3, $urandom);
    retire(2'd0, 32'd0);
    do_fetch($urandom_range(0, 2), $urandom);
    retire(2'd0, 32'd0);
    do_fetch($urandom_range(0, 2), $urandom);
    retire(2'd0, 32'd0);

    // Backward branch at BFC00010 with a J in its delay slot.
    check("br_pc", pc_out, 32'hBFC00010);
    do_fetch(0, 32'h1000FFFE);
    retire(2'd1, 32'd0);
    check("delay_addr", bus.avm_address, 32'hBFC00014);
    do_fetch(1, $urandom);
    retire(2'd2, 32'd0);
    check("br_target", bus.avm_address, 32'hBFC0000C);

    // Randomized program flow.
    for (int i = 0; i < 40 && !m_halted; i++) begin
      do_fetch($urandom_range(0, 3), $urandom);
      r = int'($urandom_range(0, 9));
      c = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      rt = $urandom & 32'hFFFF_FFFC;
      if (rt == 32'd0) rt = 32'hBFC00040;
      retire(c, rt);
    end

    // Misaligned register-jump target.
    apply_reset();
    do_fetch(0, $urandom);
    retire(2'd3, 32'hBFC00102);
    do_fetch(1, $urandom);
    retire(2'd0, 32'd0);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    check_bit("mis_fault",  fetch_fault, 1'b1);
    check_bit("mis_active", active, 1'b0);
    check("mis_pc",         pc_out, 32'hBFC00004);
    idle_halted(2);
`else
    check("mis_addr", bus.avm_address, 32'hBFC00100);
    bus.avm_waitrequest = 1'b1;
    tick();
    check("mis_stall_addr",    bus.avm_address, 32'hBFC00100);
    check_bit("mis_stall_read", bus.avm_read, 1'b1);
    check_bit("mis_fault",      fetch_fault, 1'b0);
`endif

    // Reset asserted between edges while a read is stalled.
    #2;
    reset = 1'b1;
    #1;
    check_bit("midrst_read",  bus.avm_read, 1'b1);
    check("midrst_addr",      bus.avm_address, 32'hBFC00000);
    check_bit("midrst_valid", instr_valid, 1'b0);
    check_bit("midrst_fault", fetch_fault, 1'b0);
    tick();
    reset = 1'b0;
    model_reset();

    // JR to address 0: delay slot retires, then permanent halt.
    do_fetch(2, $urandom);
    retire(2'd3, 32'd0);
    check("jr0_delay_addr", bus.avm_address, 32'hBFC00004);
    do_fetch(0, $urandom);
    retire(2'd0, 32'd0);
    check_bit("jr0_active", active, 1'b0);
    check("jr0_pc", pc_out, 32'hBFC00004);
    idle_halted(4);

    // PC+4 wrapping from FFFFFFFC to 0 halts.
    apply_reset();
    do_fetch(0, $urandom);
    retire(2'd3, 32'hFFFFFFF8);
    do_fetch(0, $urandom);
    retire(2'd0, 32'd0);
    check("wrap_addr", bus.avm_address, 32'hFFFFFFF8);
    do_fetch(1, $urandom);
    retire(2'd0, 32'd0);
    do_fetch(0, $urandom);
    retire(2'd0, 32'd0);
    check_bit("wrap_active", active, 1'b0);
    check("wrap_pc", pc_out, 32'hFFFFFFFC);
    idle_halted(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
